iterative_divider_64_32: RTL and testbench

- Sequential restoring divider. Computes the inverse of the iterative 32x32->64 Karatsuba multiplier: it divides a 64-bit product-width dividend by a 32-bit divisor.
- Returns a 32-bit quotient and a 32-bit remainder, retiring one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath and is driven by a start/busy/done handshake.

---
 rtl/iterative_divider_64_32.sv | 106 ++++++++++
 tb/tb_iterative_divider_64_32.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider_64_32.sv
// Restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient, remainder.
// Ports: clk, rst (async low), start, dividend, divisor -> quotient, remainder, busy, done, div_by_zero, overflow.
module iterative_divider_64_32 #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_div;
  // Partial remainder stays below the divisor between steps, so its
  // (N+1)th bit is always zero and only the shifted trial value needs it.
  logic [N-1:0]    r_rem;
  logic [N-1:0]    r_q;
  logic [CW-1:0]   r_cnt;

  logic [N:0]      w_rt;
  logic            w_ge;
  logic [N-1:0]    w_sub;

  assign w_rt  = {r_rem, r_q[N-1]};
  assign w_ge  = w_rt >= {1'b0, r_div};
  // Difference is below the divisor, so the low N bits are exact.
  assign w_sub = w_rt[N-1:0] - r_div;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_div       <= divisor;
            r_rem       <= dividend[2*N-1:N];
            r_q         <= dividend[N-1:0];
            r_cnt       <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (divisor == '0) begin
              div_by_zero <= 1'b1;
              r_state     <= S_DONE;
            end else if (dividend[2*N-1:N] >= divisor) begin
              overflow <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              busy    <= 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_ge ? w_sub : w_rt[N-1:0];
          r_q   <= {r_q[N-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(N - 1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (div_by_zero || overflow) begin
            // Error path: Q still holds the untouched dividend low half.
            quotient  <= '1;
            remainder <= r_q;
          end else begin
            quotient  <= r_q;
            remainder <= r_rem;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider_64_32.sv
// Self-checking bench for iterative_divider_64_32.
// Table vectors, corner sequences and random ops against an arithmetic model.
module tb_iterative_divider_64_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  iterative_divider_64_32 dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] dd;
    logic [31:0] dv;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    logic        o;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [63:0] dd,
                                input logic [31:0] dv,
                                output logic [31:0] q,
                                output logic [31:0] r,
                                output logic z, output logic o);
    z = 0;
    o = 0;
    if (dv == 0) begin
      z = 1; q = '1; r = dd[31:0];
    end else if (dd[63:32] >= dv) begin
      o = 1; q = '1; r = dd[31:0];
    end else begin
      q = 32'(dd / {32'd0, dv});
      r = 32'(dd % {32'd0, dv});
    end
  endfunction

  // Issue one op, wait for done, check results, latency, busy and pulse width.
  task automatic run_op(input string nm, input logic [63:0] dd,
                        input logic [31:0] dv, input logic [31:0] eq,
                        input logic [31:0] er, input logic ez,
                        input logic eo, input bit scramble);
    int lat;
    int bad_busy;
    logic b0;
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1;
    @(posedge clk);
    #1;
    start = 0;
    b0 = busy;
    lat = 0;
    bad_busy = 0;
    while (!done && lat < 60) begin
      if (scramble) begin
        start    = $urandom_range(0, 1) == 1;
        dividend = {$urandom, $urandom};
        divisor  = $urandom;
      end
      @(posedge clk);
      lat++;
      #1;
      if (!done && !busy) bad_busy++;
    end
    start = 0;
    chk({nm, " latency"}, 64'(lat), (ez || eo) ? 64'd1 : 64'd33);
    chk({nm, " busy_at_start"}, 64'(b0), 64'(!(ez || eo)));
    chk({nm, " busy_gaps"}, 64'(bad_busy), 64'd0);
    chk({nm, " quotient"}, 64'(quotient), 64'(eq));
    chk({nm, " remainder"}, 64'(remainder), 64'(er));
    chk({nm, " div_by_zero"}, 64'(div_by_zero), 64'(ez));
    chk({nm, " overflow"}, 64'(overflow), 64'(eo));
    chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk({nm, " done_pulse"}, 64'(done), 64'd0);
  endtask

  vec_t tbl[7];

  initial begin
    logic [63:0] dd;
    logic [31:0] dv, eq, er;
    logic ez, eo;
    int n;

    tbl[0] = '{64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0};
    tbl[1] = '{64'hFFFFFFFE_00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,
               1'b0, 1'b0};
    tbl[2] = '{64'h00000000_12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678,
               1'b1, 1'b0};
    tbl[3] = '{64'h00000001_00000000, 32'd1, 32'hFFFFFFFF, 32'd0,
               1'b0, 1'b1};
    tbl[4] = '{64'h00000000_FFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0,
               1'b0, 1'b0};
    tbl[5] = '{64'd0, 32'h9ABCDEF0, 32'h12345678, 32'd5, 1'b0, 1'b0};
    tbl[5].dd = 64'h12345678 * 64'h9ABCDEF0 + 64'd5;
    tbl[6] = '{64'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0};

    rst = 0;
    start = 0;
    dividend = '0;
    divisor = '0;
    #23;
    chk("reset outputs",
        {26'd0, quotient, busy, done, div_by_zero, overflow, 2'b00},
        64'd0);
    chk("reset remainder", 64'(remainder), 64'd0);
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].dd, tbl[i].dv, tbl[i].q,
             tbl[i].r, tbl[i].z, tbl[i].o, 1'b0);

    // Operands and start scrambled during RUN must not disturb the result.
    run_op("scramble", tbl[5].dd, tbl[5].dv, 32'h12345678, 32'd5,
           1'b0, 1'b0, 1'b1);

    // Previous result is held while the next op is in RUN.
    @(negedge clk);
    dividend = 64'd1000;
    divisor  = 32'd3;
    start    = 1;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    chk("hold quotient", 64'(quotient), 64'h12345678);
    chk("hold remainder", 64'(remainder), 64'd5);
    chk("hold busy", 64'(busy), 64'd1);

    // Asynchronous reset mid-iteration aborts with no done pulse.
    #2;
    rst = 0;
    #1;
    chk("abort outputs",
        {26'd0, quotient, busy, done, div_by_zero, overflow, 2'b00},
        64'd0);
    chk("abort remainder", 64'(remainder), 64'd0);
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    chk("abort no done", 64'(n), 64'd0);
    @(negedge clk);
    rst = 1;
    run_op("restart", 64'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 1'b0);

    // start held high: new op begins on the first IDLE cycle after DONE.
    @(negedge clk);
    dividend = 64'd100;
    divisor  = 32'd7;
    start    = 1;
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("held first done", 64'(n), 64'd34);
    chk("held first q", 64'(quotient), 64'd14);
    dividend = 64'd1000;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    chk("held restart busy", 64'(busy), 64'd1);
    start = 0;
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("held second latency", 64'(n), 64'd33);
    chk("held second q", 64'(quotient), 64'd333);
    chk("held second r", 64'(remainder), 64'd1);

    for (int i = 0; i < 150; i++) begin
      dv = $urandom;
      case ($urandom_range(0, 9))
        0: dv = 0;
        1: dd = {$urandom | dv, $urandom};
        2: dd = {32'd0, $urandom};
        default: ;
      endcase
      if (dv != 0 && $urandom_range(0, 9) > 2)
        dd = {$urandom % dv, $urandom};
      else if (dv == 0)
        dd = {$urandom, $urandom};
      model(dd, dv, eq, er, ez, eo);
      run_op($sformatf("rnd%0d", i), dd, dv, eq, er, ez, eo, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
